// File: rtl/seq_circuit_stepper_pkg.sv
// Shared types and circuit equations for the sequential-circuit stepper.
// The next-state and output functions describe the two-flip-flop circuit
// being stepped; they are kept here so anything that needs the reference
// behaviour uses one definition.
package seq_circuit_stepper_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RST_DUT  = 3'd1,
      ST_WAIT_VEC = 3'd2,
      ST_APPLY    = 3'd3,
      ST_CLK_HI   = 3'd4,
      ST_CLK_LO   = 3'd5,
      ST_SAMPLE   = 3'd6,
      ST_DONE     = 3'd7
   } state_e;

   // q is {q1, q2}; returns {q1_next, q2_next} for one falling edge
   function automatic logic [1:0] next_q(input logic [1:0] q, input logic a, input logic b);
      logic d1;
      d1 = a | (b & ~q[0]);
      return {d1, q[1] & ~d1};
   endfunction

   // q is {q1, q2}; returns the settled {y, z}
   function automatic logic [1:0] exp_yz(input logic [1:0] q, input logic b);
      return {q[1], ~q[1] | (~q[0] & b)};
   endfunction

endpackage

// File: rtl/seq_circuit_stepper_model.sv
// Cycle-accurate reference of the stepped circuit: holds q1/q2 and exposes
// the y/z the real circuit should show for the currently applied b.
module seq_circuit_model
   import seq_circuit_stepper_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic step_i,
   input  logic a_i,
   input  logic b_i,
   output logic exp_y_o,
   output logic exp_z_o
);

   logic [1:0] q_q, q_d;

   // clear wins over step; step mirrors one falling edge of the circuit clock
   always_comb begin
      q_d = q_q;
      if (clear_i) begin
         q_d = '0;
      end else if (step_i) begin
         q_d = next_q(q_q, a_i, b_i);
      end
   end

   // model state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign {exp_y_o, exp_z_o} = exp_yz(q_q, b_i);

endmodule

// File: rtl/seq_circuit_stepper.sv
// Steps the external two-flip-flop circuit through a vector stream: applies
// a/b, lets the gates settle, issues one falling clock edge, settles again,
// samples y/z and compares against the internal reference model.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no run yet; circuit held in reset
// RST_DUT  | circuit reset held for SETTLE_CYCLES
// WAIT_VEC | vec_ready high, waiting for the next vector
// APPLY    | a/b applied, settling with circuit clock low
// CLK_HI   | circuit clock high for one cycle; leaving it is the active edge
// CLK_LO   | settling after the falling edge
// SAMPLE   | capture y/z and compare with the model
// DONE     | run finished; circuit held in reset, counters kept
module seq_circuit_stepper
   import seq_circuit_stepper_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             vec_valid,
   input  logic             vec_a,
   input  logic             vec_b,
   input  logic             vec_last,
   output logic             vec_ready,
   output logic             dut_rst,
   output logic             dut_clk,
   output logic             dut_a,
   output logic             dut_b,
   input  logic             dut_y,
   input  logic             dut_z,
   output logic             res_valid,
   output logic             res_y,
   output logic             res_z,
   output logic             res_err,
   output logic [CNT_W-1:0] step_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             busy,
   output logic             done
);

   localparam int               TMR_W    = $clog2(SETTLE_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SETTLE_CYCLES - 1);

   state_e             state_q, state_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic               dut_rst_q, dut_rst_d;
   logic               dut_clk_q, dut_clk_d;
   logic               a_q, a_d, b_q, b_d, last_q, last_d;
   logic               res_valid_q, res_valid_d;
   logic               res_y_q, res_y_d, res_z_q, res_z_d, res_err_q, res_err_d;
   logic [CNT_W-1:0]   step_q, step_d, err_q, err_d;
   logic               model_clear, model_step;
   logic               exp_y, exp_z;
   logic               mismatch;
   logic               tmr_tc;

   assign tmr_tc   = (tmr_q == '0);
   assign mismatch = (dut_y != exp_y) || (dut_z != exp_z);

   seq_circuit_model u_model (
      .clk     (clk),
      .rst     (rst),
      .clear_i (model_clear),
      .step_i  (model_step),
      .a_i     (a_q),
      .b_i     (b_q),
      .exp_y_o (exp_y),
      .exp_z_o (exp_z)
   );

   // sequencing, vector latch, result capture and counter updates
   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_tc ? tmr_q : tmr_q - TMR_W'(1);
      a_d         = a_q;
      b_d         = b_q;
      last_d      = last_q;
      res_valid_d = 1'b0;
      res_y_d     = res_y_q;
      res_z_d     = res_z_q;
      res_err_d   = res_err_q;
      step_d      = step_q;
      err_d       = err_q;
      model_clear = 1'b0;
      model_step  = 1'b0;
      vec_ready   = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_RST_DUT;
               tmr_d       = TMR_LOAD;
               step_d      = '0;
               err_d       = '0;
               model_clear = 1'b1;
            end
         end
         ST_RST_DUT: begin
            if (tmr_tc) state_d = ST_WAIT_VEC;
         end
         ST_WAIT_VEC: begin
            vec_ready = 1'b1;
            if (vec_valid) begin
               a_d     = vec_a;
               b_d     = vec_b;
               last_d  = vec_last;
               tmr_d   = TMR_LOAD;
               state_d = ST_APPLY;
            end
         end
         ST_APPLY: begin
            if (tmr_tc) state_d = ST_CLK_HI;
         end
         ST_CLK_HI: begin
            model_step = 1'b1;
            tmr_d      = TMR_LOAD;
            state_d    = ST_CLK_LO;
         end
         ST_CLK_LO: begin
            if (tmr_tc) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            res_valid_d = 1'b1;
            res_y_d     = dut_y;
            res_z_d     = dut_z;
            res_err_d   = mismatch;
            step_d      = step_q + CNT_W'(1);
            if (mismatch && (err_q != '1)) err_d = err_q + CNT_W'(1);
            state_d     = last_q ? ST_DONE : ST_WAIT_VEC;
         end
         default: state_d = ST_IDLE;
      endcase
      dut_rst_d = (state_d == ST_IDLE) || (state_d == ST_RST_DUT) || (state_d == ST_DONE);
      dut_clk_d = (state_d == ST_CLK_HI);
   end

   // circuit-facing pins are registered so the circuit clock and reset are glitch-free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         tmr_q       <= '0;
         dut_rst_q   <= 1'b1;
         dut_clk_q   <= 1'b0;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         last_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_y_q     <= 1'b0;
         res_z_q     <= 1'b0;
         res_err_q   <= 1'b0;
         step_q      <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         dut_rst_q   <= dut_rst_d;
         dut_clk_q   <= dut_clk_d;
         a_q         <= a_d;
         b_q         <= b_d;
         last_q      <= last_d;
         res_valid_q <= res_valid_d;
         res_y_q     <= res_y_d;
         res_z_q     <= res_z_d;
         res_err_q   <= res_err_d;
         step_q      <= step_d;
         err_q       <= err_d;
      end
   end

   assign dut_rst   = dut_rst_q;
   assign dut_clk   = dut_clk_q;
   assign dut_a     = a_q;
   assign dut_b     = b_q;
   assign res_valid = res_valid_q;
   assign res_y     = res_y_q;
   assign res_z     = res_z_q;
   assign res_err   = res_err_q;
   assign step_cnt  = step_q;
   assign err_cnt   = err_q;
   assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_circuit_stepper.sv
// Bench for seq_circuit_stepper: a behavioural copy of the stepped circuit
// with optional output faults, a driver issuing random vectors, and a monitor
// that checks each result against a queue of expected responses.
module tb_seq_circuit_stepper;

   localparam int S  = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0, vec_valid = 1'b0, vec_a = 1'b0, vec_b = 1'b0, vec_last = 1'b0;
   logic          vec_ready, dut_rst, dut_clk, dut_a, dut_b, dut_y, dut_z;
   logic          res_valid, res_y, res_z, res_err, busy, done;
   logic [CW-1:0] step_cnt, err_cnt;

   int nchecks = 0;
   int nerrors = 0;

   always #5 clk = ~clk;

   seq_circuit_stepper #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .vec_valid(vec_valid), .vec_a(vec_a), .vec_b(vec_b), .vec_last(vec_last),
      .vec_ready(vec_ready), .dut_rst(dut_rst), .dut_clk(dut_clk),
      .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y), .dut_z(dut_z),
      .res_valid(res_valid), .res_y(res_y), .res_z(res_z), .res_err(res_err),
      .step_cnt(step_cnt), .err_cnt(err_cnt), .busy(busy), .done(done)
   );

   // the circuit on the board: two negative-edge flops with async reset
   logic c_q1, c_q2;
   bit   fault_y_inv = 1'b0;
   bit   fault_z0    = 1'b0;

   always @(negedge dut_clk or posedge dut_rst) begin
      if (dut_rst) begin
         c_q1 <= 1'b0;
         c_q2 <= 1'b0;
      end else begin
         c_q1 <= dut_a | (dut_b & ~c_q2);
         c_q2 <= c_q1 & ~(dut_a | (dut_b & ~c_q2));
      end
   end

   assign dut_y = fault_y_inv ? ~c_q1 : c_q1;
   assign dut_z = fault_z0 ? 1'b0 : (~c_q1 | (~c_q2 & dut_b));

   typedef struct {
      bit y;
      bit z;
      bit err;
      int scnt;
      int ecnt;
   } res_t;

   res_t exp_q[$];
   bit   m_q1, m_q2;
   int   m_scnt, m_ecnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      nchecks++;
      if (act !== exp_v) begin
         nerrors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   // monitor: every result pulse must match the oldest expected response
   res_t mon_r;
   always @(negedge clk) begin
      if (res_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_res_valid", {31'd0, res_valid}, 32'd0);
         end else begin
            mon_r = exp_q.pop_front();
            check("res_y", res_y, mon_r.y);
            check("res_z", res_z, mon_r.z);
            check("res_err", res_err, mon_r.err);
            check("res_step_cnt", step_cnt, mon_r.scnt);
            check("res_err_cnt", err_cnt, mon_r.ecnt);
         end
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_ctl"}, {dut_rst, dut_clk, dut_a, dut_b, vec_ready, busy, done}, 32'b1000000);
      check({tag, "_res"}, {res_valid, res_y, res_z, res_err}, 32'd0);
      check({tag, "_cnt"}, {step_cnt, err_cnt}, 32'd0);
   endtask

   task automatic run_start();
      @(negedge clk);
      start  = 1'b1;
      m_q1   = 1'b0;
      m_q2   = 1'b0;
      m_scnt = 0;
      m_ecnt = 0;
      @(negedge clk);
      start = 1'b0;
   endtask

   // offer one vector, wait for the handshake, then record what must come back
   task automatic send(input bit a, input bit b, input bit last);
      int n;
      bit d1, iy, iz, oy, oz;
      res_t r;
      vec_a = a; vec_b = b; vec_last = last; vec_valid = 1'b1;
      n = 0;
      while (!vec_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!vec_ready) begin
         check("vec_ready_timeout", {31'd0, vec_ready}, 32'd1);
         vec_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 vec_valid = 1'b0;
      d1   = a | (b & !m_q2);
      m_q2 = m_q1 & !d1;
      m_q1 = d1;
      iy = m_q1;
      iz = !m_q1 | (!m_q2 & b);
      oy = fault_y_inv ? !iy : iy;
      oz = fault_z0 ? 1'b0 : iz;
      r.y    = oy;
      r.z    = oz;
      r.err  = (oy != iy) || (oz != iz);
      m_scnt = (m_scnt + 1) % (1 << CW);
      if (r.err && m_ecnt < (1 << CW) - 1) m_ecnt++;
      r.scnt = m_scnt;
      r.ecnt = m_ecnt;
      exp_q.push_back(r);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("done", {31'd0, done}, 32'd1);
   endtask

   task automatic random_run(input int nvec, input int max_gap);
      run_start();
      for (int i = 0; i < nvec; i++) begin
         repeat ($urandom_range(0, max_gap)) @(negedge clk);
         send(1'($urandom), 1'($urandom), i == nvec - 1);
      end
      wait_done();
      check("run_step_cnt", step_cnt, m_scnt);
      check("run_err_cnt", err_cnt, m_ecnt);
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, lat, hi;
      bit saw_clk, saw_res, all_busy;

      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("idle");

      // directed three-step sequence
      run_start();
      send(1'b1, 1'b0, 1'b0);
      send(1'b0, 1'b1, 1'b0);
      send(1'b0, 1'b0, 1'b1);
      wait_done();
      check("seq3_step_cnt", step_cnt, 32'd3);
      check("seq3_err_cnt", err_cnt, 32'd0);
      check("seq3_busy", {31'd0, busy}, 32'd0);

      // timing: circuit reset length, accept-to-result latency, clock-high width
      run_start();
      n = 0;
      while (dut_rst && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("dut_rst_cycles", n, S);
      send(1'b1, 1'b1, 1'b1);
      lat = 0;
      hi  = 0;
      while (!res_valid && lat < 100) begin
         @(negedge clk);
         lat++;
         if (dut_clk) hi++;
      end
      check("latency", lat, 2 * S + 3);
      check("dut_clk_hi_cycles", hi, 1);
      wait_done();

      // z stuck low: errors on steps 2 and 3
      fault_z0 = 1'b1;
      run_start();
      send(1'b1, 1'b0, 1'b0);
      send(1'b0, 1'b1, 1'b0);
      send(1'b0, 1'b0, 1'b1);
      wait_done();
      check("z0_err_cnt", err_cnt, 32'd2);
      fault_z0 = 1'b0;

      // starved vector source; a start pulse while busy must be ignored
      run_start();
      n = 0;
      while (!vec_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      saw_clk = 1'b0; saw_res = 1'b0; all_busy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         start = (i == 5);
         @(negedge clk);
         if (dut_clk) saw_clk = 1'b1;
         if (res_valid) saw_res = 1'b1;
         if (!busy) all_busy = 1'b0;
      end
      start = 1'b0;
      check("starve_dut_clk", {31'd0, saw_clk}, 32'd0);
      check("starve_res_valid", {31'd0, saw_res}, 32'd0);
      check("starve_busy", {31'd0, all_busy}, 32'd1);
      check("starve_vec_ready", {31'd0, vec_ready}, 32'd1);
      send(1'($urandom), 1'($urandom), 1'b1);
      wait_done();
      check("starve_step_cnt", step_cnt, 32'd1);

      // reset during CLK_LO of step 2
      run_start();
      send(1'b1, 1'b0, 1'b0);
      send(1'b0, 1'b1, 1'b0);
      n = 0;
      while (!dut_clk && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("clk_hi_seen", {31'd0, dut_clk}, 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check_reset_state("midrst");
      @(negedge clk);
      check_reset_state("midrst_next");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (S * 3) @(negedge clk);
      check_reset_state("post_rst_idle");
      random_run(5, 2);

      // random vectors, ideal circuit
      random_run(12, 3);
      random_run(8, 0);

      // 300 vectors with y inverted: step count wraps, errors saturate
      fault_y_inv = 1'b1;
      random_run(300, 0);
      check("wrap_step_cnt", step_cnt, 32'd44);
      check("sat_err_cnt", err_cnt, 32'd255);
      fault_y_inv = 1'b0;

      repeat (3) @(negedge clk);
      check("pending_results", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule

// File: doc/seq_circuit_stepper.md
Name: seq_circuit_stepper

Overview:
- Controller that steps the two-flip-flop negative-edge sequential circuit (inputs a/b, outputs y/z, gate-delay model) through a stream of input vectors.
- Owns the circuit's clock and reset: applies each vector, waits for gate settling, issues one falling edge, waits again, then samples y/z.
- Compares each sample against an internal cycle-accurate reference model and counts mismatches.
- Sits between a vector source (testbench or pattern ROM) and the circuit instance on the lab board/bench.

Parameters:
SETTLE_CYCLES, 4, clk cycles held before and after each DUT falling edge (must be >= 1; covers 3 gate levels x 10 ns at 100 MHz)
CNT_W, 8, width of step and error counters

Ports:
clk  input  1  controller clock, posedge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; starts a run (ignored unless IDLE or DONE)
vec_valid  input  1  vector available
vec_a  input  1  a value for this step
vec_b  input  1  b value for this step
vec_last  input  1  this vector ends the run
vec_ready  output  1  controller accepts vector this cycle
dut_rst  output  1  reset to circuit
dut_clk  output  1  clock to circuit (falling edge is active)
dut_a  output  1  drives circuit a
dut_b  output  1  drives circuit b
dut_y  input  1  circuit y
dut_z  input  1  circuit z
res_valid  output  1  one-cycle pulse per completed step
res_y  output  1  sampled y
res_z  output  1  sampled z
res_err  output  1  sample differs from model (valid with res_valid)
step_cnt  output  CNT_W  steps completed this run
err_cnt  output  CNT_W  mismatches this run, saturating
busy  output  1  high in any state except IDLE/DONE
done  output  1  high in DONE until next start

Behaviour:
- Reset (async, rst=1): state IDLE; dut_rst=1, dut_clk=0, dut_a=dut_b=0, vec_ready=0, res_*=0, step_cnt=err_cnt=0, busy=0, done=0, model q1=q2=0.
- States: IDLE, RST_DUT, WAIT_VEC, APPLY, CLK_HI, CLK_LO, SAMPLE, DONE.
- IDLE/DONE: dut_rst=1. On start: clear counters, clear done, model q1=q2=0, go to RST_DUT.
- RST_DUT: dut_rst=1 for SETTLE_CYCLES cycles, then WAIT_VEC with dut_rst=0.
- WAIT_VEC: vec_ready=1. On vec_valid: latch vec_a/b into dut_a/b, latch vec_last, go to APPLY.
- APPLY: SETTLE_CYCLES cycles with dut_clk=0, then CLK_HI.
- CLK_HI: one cycle with dut_clk=1. Leaving it drops dut_clk, which is the circuit's active edge.
- On that same transition, update the model:
  - d1 = a | (b & ~q2)
  - d2 = q1 & ~d1
  - q1 <= d1, q2 <= d2
- CLK_LO: SETTLE_CYCLES cycles with dut_clk=0, then SAMPLE.
- SAMPLE (one cycle): capture dut_y/dut_z and compute the expected values:
  - exp_y = q1
  - exp_z = ~q1 | (~q2 & b), using the current dut_b
- Cycle after SAMPLE: res_valid=1 with res_y/res_z/res_err; step_cnt+1 (wraps); err_cnt+1 if res_err (saturates at all-ones). Go to DONE if latched last, else WAIT_VEC.
- Latency: vector accept -> res_valid = 2*SETTLE_CYCLES + 3 cycles. Minimum vec_ready spacing is the same.
- dut_a/dut_b hold their value from accept until the next accept. They are never changed while dut_clk=1.
- start while busy: ignored. vec_valid outside WAIT_VEC: ignored, no handshake.
- rst mid-step: immediate return to reset values. The DUT is reset, no partial result is reported, and counters clear.

Decomposition:
- Shared package: state encoding constants, and the model equations as a function (next_q, exp_yz) so benches reuse them.
- One natural sub-module: seq_circuit_model, holding the q1/q2 registers plus the expected y/z logic, with load/step/clear inputs.

Test Plan:
- Reset then start, vectors (a,b)=(1,0),(0,1),(0,0 last) -> res (y,z) = (1,0),(1,1),(0,1); err_cnt=0; step_cnt=3; done=1.
- SETTLE_CYCLES=4, single vector -> res_valid exactly 11 cycles after accept; dut_clk high exactly 1 cycle; dut_rst high 4 cycles after start.
- Force dut_z stuck at 0, run the 3-vector sequence -> res_err pattern 0,1,1; err_cnt=2.
- vec_valid held low 20 cycles in WAIT_VEC -> dut_clk stays 0, no res_valid, busy=1.
- Assert rst during CLK_LO of step 2 -> next cycle all outputs at reset values, no res_valid; a new start reruns from step_cnt=0.
- 300 vectors with CNT_W=8 and dut_y inverted -> step_cnt wraps to 44; err_cnt saturates at 255.
